// File: rtl/output_collector_pkg.sv
// Shared control definitions for the output collector and its FIFO.
// The state encoding is fixed so other stages can decode a probed state value.
package output_collector_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int DEPTH_DEF = 16;
  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

endpackage

// File: rtl/output_collector_sync_fifo.sv
// First-word fall-through synchronous FIFO. A push into a full FIFO is accepted
// only when a pop happens in the same cycle. A pop from an empty FIFO is ignored.
module sync_fifo
  import output_collector_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF + 1,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // The extra pointer bit tells a full FIFO apart from an empty one.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage has no reset; empty/full come only from the pointers, so
  // stale contents are never observed and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Gated to zero when empty so the output is a clean zero after clear.
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/output_collector.sv
// Collects a framed batch of result words into a FIFO and presents it to the host
// on a valid/ready stream with a last-word marker, done pulse and sticky error flags.
module output_collector
  import output_collector_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] y_in,
  input  logic             y_valid,
  input  logic [CNT_W-1:0] out_count,
  input  logic             out_count_valid,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic             proto_err
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [CNT_W-1:0] remaining;

  logic             y_evt;
  logic             cnt_evt;
  logic             is_last;
  logic             push_req;
  logic             pop_fire;
  logic             push_ok;
  logic             fifo_full;
  logic             fifo_empty;
  logic [WIDTH:0]   fifo_din;
  logic [WIDTH:0]   fifo_dout;

  // Input events are gated by enable; the host side drains regardless.
  assign y_evt    = enable && y_valid;
  assign cnt_evt  = enable && out_count_valid;
  assign is_last  = (remaining == CNT_ONE);
  assign push_req = (state == COLLECT) && y_evt;
  assign pop_fire = !fifo_empty && m_ready;
  assign push_ok  = push_req && (!fifo_full || pop_fire);
  assign fifo_din = {is_last, y_in};

  sync_fifo #(
    .WIDTH (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clear (clear),
    .push  (push_req),
    .pop   (m_ready),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign m_data  = fifo_dout[WIDTH-1:0];
  assign m_last  = fifo_dout[WIDTH];
  assign m_valid = !fifo_empty;
  assign busy    = (state != IDLE);

  // NOTE: all state here uses non-blocking assignments so every branch sees
  // the pre-edge values of state/remaining regardless of statement order.
  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= IDLE;
      remaining <= '0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      done <= 1'b0;
      if (push_req && !push_ok) overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (y_evt) proto_err <= 1'b1;
          if (cnt_evt) begin
            if (out_count != '0) begin
              remaining <= out_count;
              state     <= COLLECT;
            end else begin
              done <= 1'b1;
            end
          end
        end

        COLLECT: begin
          if (cnt_evt) proto_err <= 1'b1;
          if (y_evt && remaining != '0) begin
            remaining <= remaining - CNT_ONE;
            if (is_last) begin
              // A dropped final word can never be marked, so close the batch now.
              if (push_ok) begin
                state <= DRAIN;
              end else begin
                state <= IDLE;
                done  <= 1'b1;
              end
            end
          end
        end

        DRAIN: begin
          if (y_evt || cnt_evt) proto_err <= 1'b1;
          if (pop_fire && m_last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_collector.sv
// Directed self-checking bench for output_collector: framing, backpressure,
// overflow, zero-length batches, protocol errors and mid-batch clear.
module tb_output_collector;

  logic        clk = 1'b0;
  logic        clear;
  logic        enable;
  logic [31:0] y_in;
  logic        y_valid;
  logic [31:0] out_count;
  logic        out_count_valid;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        busy;
  logic        done;
  logic        overflow;
  logic        proto_err;

  int checks = 0;
  int passed = 0;

  output_collector #(.WIDTH(32), .DEPTH(16), .CNT_W(32)) dut (
    .clk             (clk),
    .clear           (clear),
    .enable          (enable),
    .y_in            (y_in),
    .y_valid         (y_valid),
    .out_count       (out_count),
    .out_count_valid (out_count_valid),
    .m_data          (m_data),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .m_last          (m_last),
    .busy            (busy),
    .done            (done),
    .overflow        (overflow),
    .proto_err       (proto_err)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle; inputs set afterwards are sampled on the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  task automatic check_flags(input string tag, input logic exp_valid, input logic exp_busy,
                             input logic exp_done, input logic exp_ovf, input logic exp_perr);
    check({tag, ".m_valid"}, 32'(m_valid), 32'(exp_valid));
    check({tag, ".busy"}, 32'(busy), 32'(exp_busy));
    check({tag, ".done"}, 32'(done), 32'(exp_done));
    check({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
    check({tag, ".proto_err"}, 32'(proto_err), 32'(exp_perr));
  endtask

  initial begin
    clear = 1'b1; enable = 1'b1; y_in = '0; y_valid = 1'b0;
    out_count = '0; out_count_valid = 1'b0; m_ready = 1'b0;
    tick(); tick();
    clear = 1'b0;
    check("reset.m_data", m_data, 32'h0);
    check("reset.m_last", 32'(m_last), 32'h0);
    check_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // enable=0 hides an IDLE y_valid entirely
    enable = 1'b0; y_valid = 1'b1; y_in = 32'h99;
    tick();
    check_flags("gated", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    enable = 1'b1; y_valid = 1'b0;

    // Basic batch of 3 with the host always ready
    m_ready = 1'b1;
    out_count = 32'd3; out_count_valid = 1'b1;
    tick();
    check("basic.busy_start", 32'(busy), 32'h1);
    out_count_valid = 1'b0;
    y_valid = 1'b1; y_in = 32'hA;
    tick();
    check("basic.d0", m_data, 32'hA);
    check("basic.l0", 32'(m_last), 32'h0);
    check("basic.v0", 32'(m_valid), 32'h1);
    y_in = 32'hB;
    tick();
    check("basic.d1", m_data, 32'hB);
    check("basic.l1", 32'(m_last), 32'h0);
    y_in = 32'hC;
    tick();
    y_valid = 1'b0;
    check("basic.d2", m_data, 32'hC);
    check("basic.l2", 32'(m_last), 32'h1);
    check("basic.busy_drain", 32'(busy), 32'h1);
    check("basic.done_early", 32'(done), 32'h0);
    tick();
    check_flags("basic.end", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check("basic.done_once", 32'(done), 32'h0);

    // Backpressure: 4 words held for 10 cycles, then drained in order
    m_ready = 1'b0;
    out_count = 32'd4; out_count_valid = 1'b1;
    tick();
    out_count_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      y_valid = 1'b1; y_in = 32'(k);
      tick();
    end
    y_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      check("bp.stall_data", m_data, 32'h1);
      tick();
    end
    check("bp.stall_valid", 32'(m_valid), 32'h1);
    m_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check("bp.data", m_data, 32'(k));
      check("bp.last", 32'(m_last), (k == 4) ? 32'h1 : 32'h0);
      tick();
    end
    check_flags("bp.end", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Overflow: 20 words into 16 entries, final word lost
    m_ready = 1'b0;
    out_count = 32'd20; out_count_valid = 1'b1;
    tick();
    out_count_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      y_valid = 1'b1; y_in = 32'(k);
      tick();
      if (k == 16) check("ovf.no_flag_at_16", 32'(overflow), 32'h0);
    end
    y_valid = 1'b0;
    check_flags("ovf.end", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    check("ovf.done_once", 32'(done), 32'h0);
    m_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      check("ovf.data", m_data, 32'(k));
      check("ovf.last", 32'(m_last), 32'h0);
      tick();
    end
    check_flags("ovf.drained", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Zero-length batch
    out_count = 32'd0; out_count_valid = 1'b1;
    tick();
    out_count_valid = 1'b0;
    check_flags("zero.pulse", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    check_flags("zero.after", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Protocol error: y_valid while idle
    y_valid = 1'b1; y_in = 32'h55;
    tick();
    y_valid = 1'b0;
    check_flags("perr.idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_flags("perr.cleared", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Protocol error: second count during COLLECT is ignored
    out_count = 32'd2; out_count_valid = 1'b1;
    tick();
    out_count = 32'd7;
    tick();
    out_count_valid = 1'b0;
    check("perr.collect", 32'(proto_err), 32'h1);
    y_valid = 1'b1; y_in = 32'h11;
    tick();
    check("perr.d0", m_data, 32'h11);
    check("perr.l0", 32'(m_last), 32'h0);
    y_in = 32'h22;
    tick();
    y_valid = 1'b0;
    check("perr.d1", m_data, 32'h22);
    check("perr.l1", 32'(m_last), 32'h1);
    tick();
    check_flags("perr.end", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Clear mid-batch, then a fresh batch of 2
    m_ready = 1'b0;
    out_count = 32'd5; out_count_valid = 1'b1;
    tick();
    out_count_valid = 1'b0;
    y_valid = 1'b1; y_in = 32'h1;
    tick();
    y_in = 32'h2;
    tick();
    y_valid = 1'b0;
    check("mid.pre_valid", 32'(m_valid), 32'h1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_flags("mid.cleared", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("mid.m_data", m_data, 32'h0);
    m_ready = 1'b1;
    out_count = 32'd2; out_count_valid = 1'b1;
    tick();
    out_count_valid = 1'b0;
    y_valid = 1'b1; y_in = 32'h7;
    tick();
    check("mid.d0", m_data, 32'h7);
    y_in = 32'h8;
    tick();
    y_valid = 1'b0;
    check("mid.d1", m_data, 32'h8);
    check("mid.l1", 32'(m_last), 32'h1);
    tick();
    check_flags("mid.end", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/output_collector.md
Name: output_collector

Overview:
- Downstream stage of the data interface; consumes its result stream (data word + y_valid) and per-batch expected length (out_count + out_count_valid).
- Buffers results in a FIFO, frames each batch, and presents it to the host on a valid/ready stream with a last-word marker.
- Flags lost results and protocol errors.
- Signals batch completion with a one-cycle done pulse.

Parameters:
- WIDTH, 32, data word width.
- DEPTH, 16, FIFO entries; power of two, at least 2.
- CNT_W, 32, width of the batch length counter.

Ports:
- clk  in  1  global clock, rising edge.
- clear  in  1  synchronous active-high reset.
- enable  in  1  global enable; gates the input side only.
- y_in  in  WIDTH  result word from the data interface.
- y_valid  in  1  y_in qualifier.
- out_count  in  CNT_W  expected result words for the next batch.
- out_count_valid  in  1  out_count qualifier.
- m_data  out  WIDTH  head-of-FIFO word.
- m_valid  out  1  m_data valid (FIFO not empty).
- m_ready  in  1  host accepts m_data.
- m_last  out  1  m_data is the final word of its batch.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at batch completion.
- overflow  out  1  sticky; a result word was dropped because the FIFO was full.
- proto_err  out  1  sticky; unexpected y_valid or out_count_valid.

Behaviour:
- Reset (clear=1 at posedge):
  - state=IDLE, FIFO empty, remaining=0.
  - m_valid=0, m_last=0, m_data=0, busy=0, done=0, overflow=0, proto_err=0.
  - Reset mid-batch discards all buffered data.
- Input acceptance: an input event counts only when enable=1. Output pops (m_valid&&m_ready) proceed regardless of enable.
- State IDLE:
  - out_count_valid with out_count>0: remaining<=out_count, go to COLLECT.
  - out_count_valid with out_count==0: done pulses next cycle, stay IDLE, nothing is pushed.
  - y_valid in IDLE: word dropped, proto_err<=1.
- State COLLECT:
  - Each y_valid pushes {last=(remaining==1), y_in} and decrements remaining.
  - When the push with remaining==1 occurs, go to DRAIN.
  - out_count_valid in COLLECT or DRAIN is ignored and sets proto_err.
- State DRAIN:
  - Wait until the FIFO pops the entry with last=1.
  - On that cycle: done=1 on the next cycle, go to IDLE.
  - y_valid in DRAIN: dropped, proto_err<=1.
- FIFO:
  - First-word fall-through; m_data/m_last reflect the head entry combinationally from registered storage.
  - m_valid = !empty.
  - Latency: y_valid at edge N gives m_valid=1 after edge N.
  - Push when full is accepted only if a pop occurs in the same cycle; otherwise the word is dropped and overflow<=1.
  - A dropped word still decrements remaining, so batch framing is preserved.
  - If the dropped word was the last one, the batch cannot mark m_last. In that case go directly to IDLE with a done pulse, and overflow is set.
  - Simultaneous push and pop on an empty FIFO: push only (no pop is possible when m_valid=0).
  - Pointers are log2(DEPTH)+1 bits; full/empty use the MSB compare; wrap-around is natural.
- m_data holds stable while m_valid=1 and m_ready=0.
- overflow and proto_err clear only on clear.
- remaining is unsigned CNT_W; it never decrements below 0.

Decomposition:
- Shared package (control defs): WIDTH default, state encoding constants IDLE=2'd0, COLLECT=2'd1, DRAIN=2'd2.
- One sub-module: sync_fifo (WIDTH+1 bits wide, DEPTH deep; ports push, pop, din, dout, full, empty). Reusable by other stages.
- Top-level handles counting, state machine and flags.

Test Plan:
- Basic batch: out_count=3, then y_in=0xA,0xB,0xC on consecutive cycles, m_ready=1 → m_data sequence 0xA,0xB,0xC; m_last only on 0xC; done pulses one cycle after the 0xC pop; busy returns 0.
- Backpressure: out_count=4, words 1..4, m_ready=0 for 10 cycles then 1 → 4 words delivered in order, m_data stable during stall, overflow=0.
- Overflow: DEPTH=16, out_count=20, 20 words, m_ready=0 → overflow=1; words 1..16 retained; state goes IDLE with done; the host later reads 16 words, none with m_last.
- Zero-length: out_count_valid with out_count=0 → done pulses once, m_valid stays 0, busy stays 0.
- Protocol errors: y_valid in IDLE → proto_err=1, FIFO empty; second out_count_valid during COLLECT → proto_err=1, original count honoured.
- Reset mid-batch: clear asserted after 2 of 5 words → next cycle m_valid=0, busy=0, flags 0; a new batch of 2 then completes normally.
